// File: rtl/stream_pkg.sv
// Shared definitions for the stream selector: mode encodings and round-robin search.
// Latency: n/a (package). Backpressure: n/a.
// Contents: MODE_FIXED/MODE_RR, grant_t, rr_pick() priority search helper.
package stream_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Widest configuration supported by the search helper.
   localparam int MAX_CH    = 16;
   localparam int MAX_IDX_W = 4;

   typedef struct packed {
      logic                 vld;
      logic [MAX_IDX_W-1:0] idx;
   } grant_t;

   // First requesting channel at or above ptr, wrapping at n_ch.
   // Callers keep ptr < n_ch and zero-fill req above n_ch.
   function automatic grant_t rr_pick(input logic [MAX_CH-1:0]    req,
                                      input logic [MAX_IDX_W-1:0] ptr,
                                      input logic [4:0]           n_ch);
      grant_t     g;
      logic [4:0] idx;
      g = '0;
      for (int k = 0; k < MAX_CH; k++) begin
         // ptr and k are both below n_ch, so a single subtract wraps the sum.
         idx = {1'b0, ptr} + 5'(k);
         if (idx >= n_ch) begin
            idx = idx - n_ch;
         end
         if ((5'(k) < n_ch) && !g.vld && req[idx[3:0]]) begin
            g.vld = 1'b1;
            g.idx = idx[3:0];
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: picks the first requester at or above ptr, wrapping.
// Latency: purely combinational. Backpressure: none, grant is advisory to the caller.
// Ports: req (per-channel request), ptr (search start), grant_valid, grant_idx.
module rr_arbiter
   import stream_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CH_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] ptr,
   output logic            grant_valid,
   output logic [CH_W-1:0] grant_idx
);

   logic [MAX_CH-1:0]    w_req;
   logic [MAX_IDX_W-1:0] w_ptr;
   grant_t               w_gnt;

   assign w_req       = MAX_CH'(req);
   assign w_ptr       = MAX_IDX_W'(ptr);
   assign w_gnt       = rr_pick(w_req, w_ptr, 5'(N_CH));
   assign grant_valid = w_gnt.vld;
   assign grant_idx   = CH_W'(w_gnt.idx);

endmodule

// File: rtl/stream_select.sv
// N-channel stream selector, fixed-select or round-robin, into one output register stage.
// Latency: 1 cycle from input transfer to out_valid. Backpressure: in_ready follows load_en
// (out register empty or draining), so a pop and a push in the same cycle run at full rate.
// Ports: clk, rst (sync, active-high), mode (0 fixed / 1 round-robin), sel (fixed channel),
//        in_valid/in_ready/in_data per channel, out_valid/out_ready/out_data/out_ch.
module stream_select
   import stream_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int N_CH       = 4,
   parameter int CH_W       = $clog2(N_CH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mode,
   input  logic [CH_W-1:0]            sel,
   input  logic [N_CH-1:0]            in_valid,
   input  logic [N_CH*DATA_WIDTH-1:0] in_data,
   output logic [N_CH-1:0]            in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [CH_W-1:0]            out_ch
);

   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [CH_W-1:0]       r_out_ch;
   logic [CH_W-1:0]       r_rr_ptr;

   logic                  w_load_en;
   logic                  w_sel_ok;
   logic                  w_fix_vld;
   logic                  w_arb_vld;
   logic [CH_W-1:0]       w_arb_idx;
   logic                  w_gnt_vld;
   logic [CH_W-1:0]       w_gnt_idx;
   logic [DATA_WIDTH-1:0] w_gnt_dat;
   logic                  w_push;
   logic [CH_W-1:0]       w_rr_nxt;

   rr_arbiter #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_arb (
      .req         (in_valid),
      .ptr         (r_rr_ptr),
      .grant_valid (w_arb_vld),
      .grant_idx   (w_arb_idx)
   );

   // Output register may take a new word when empty or being drained this cycle.
   assign w_load_en = !r_out_valid || out_ready;

   // sel can address past the last channel when N_CH is not a power of two.
   assign w_sel_ok  = ({1'b0, sel} < (CH_W+1)'(N_CH));
   assign w_fix_vld = w_sel_ok && in_valid[sel];

   assign w_gnt_vld = (mode == MODE_RR) ? w_arb_vld : w_fix_vld;
   assign w_gnt_idx = (mode == MODE_RR) ? w_arb_idx : sel;
   assign w_gnt_dat = in_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

   // Reset gates the handshake so no upstream word is consumed and lost.
   assign w_push    = w_gnt_vld && w_load_en && !rst;
   assign in_ready  = w_push ? (N_CH'(1) << w_gnt_idx) : '0;

   assign w_rr_nxt  = (w_gnt_idx == CH_W'(N_CH-1)) ? '0 : w_gnt_idx + CH_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_rr_ptr    <= '0;
      end else if (w_load_en) begin
         if (w_gnt_vld) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_dat;
            r_out_ch    <= w_gnt_idx;
            if (mode == MODE_RR) begin
               r_rr_ptr <= w_rr_nxt;
            end
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_select.sv
// Scoreboard bench for stream_select (N_CH=4, DATA_WIDTH=4): directed scenarios then random traffic.
// Driver predicts in_ready and queues expected output words; a monitor checks each presented word.
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_stream_select;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic [1:0]  sel;
   logic [3:0]  in_valid;
   logic [15:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_data;
   logic [1:0]  out_ch;

   int tests = 0;
   int fails = 0;
   bit done  = 1'b0;

   // Reference state: expected output occupancy, round-robin start, words owed.
   bit         m_valid     = 1'b0;
   int         m_ptr       = 0;
   bit         m_after_rst = 1'b1;
   logic [5:0] q[$];

   stream_select #(
      .DATA_WIDTH (4),
      .N_CH       (4),
      .CH_W       (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic m, input logic [1:0] s,
                        input logic [3:0] v, input logic [15:0] d, input logic o);
      int         g;
      int         c;
      bit         gnt;
      bit         ld;
      logic [3:0] exp_rdy;
      @(negedge clk);
      rst = r; mode = m; sel = s; in_valid = v; in_data = d; out_ready = o;
      #1;
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      if (m_after_rst) begin
         chk("rst_out_data", {28'b0, out_data}, 32'h0);
         chk("rst_out_ch", {30'b0, out_ch}, 32'h0);
      end
      gnt = 1'b0;
      g   = 0;
      if (!r) begin
         if (!m) begin
            if (v[s]) begin
               gnt = 1'b1;
               g   = int'(s);
            end
         end else begin
            for (int k = 0; k < 4; k++) begin
               c = (m_ptr + k) % 4;
               if (!gnt && v[c]) begin
                  gnt = 1'b1;
                  g   = c;
               end
            end
         end
      end
      ld      = !m_valid || o;
      exp_rdy = (gnt && ld) ? 4'(1 << g) : 4'b0;
      chk("in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
      if (r) begin
         m_valid     = 1'b0;
         m_ptr       = 0;
         m_after_rst = 1'b1;
         q.delete();
      end else begin
         m_after_rst = 1'b0;
         if (ld) begin
            if (gnt) begin
               q.push_back({d[g*4 +: 4], 2'(g)});
               m_valid = 1'b1;
               if (m) m_ptr = (g + 1) % 4;
            end else begin
               m_valid = 1'b0;
            end
         end
      end
   endtask

   // Monitor: whenever a word is presented it must match the oldest owed word.
   initial begin
      logic [5:0] e;
      while (!done) begin
         @(negedge clk);
         #2;
         if (rst === 1'b0 && out_valid === 1'b1) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL out_unexpected: out_valid=1 with no word owed");
            end else begin
               e = q[0];
               chk("out_data", {28'b0, out_data}, {28'b0, e[5:2]});
               chk("out_ch", {30'b0, out_ch}, {30'b0, e[1:0]});
               if (out_ready) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      logic       r;
      logic       m;
      logic [1:0] s;
      logic [3:0] v;
      logic [15:0] d;
      logic       o;

      rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'h0; in_data = 16'h0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      cycle(1'b1, 1'b0, 2'd0, 4'h0, 16'h0, 1'b0);

      // Fixed select of channel 2 with every channel valid.
      cycle(1'b0, 1'b0, 2'd2, 4'b1111, 16'h0A00, 1'b1);
      cycle(1'b0, 1'b0, 2'd0, 4'b0000, 16'h0000, 1'b1);

      // Round-robin fairness: 0,1,2,3,0.
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 2'd0, 4'b1111, 16'h4321, 1'b1);

      // Drive pointer to 3, then wrap-around grants channel 1, pointer becomes 2.
      cycle(1'b0, 1'b1, 2'd0, 4'b0100, 16'h0700, 1'b1);
      cycle(1'b0, 1'b1, 2'd0, 4'b0010, 16'h00B0, 1'b1);
      cycle(1'b0, 1'b1, 2'd0, 4'b1111, 16'hFEDC, 1'b1);

      // Backpressure: hold word 5 for three stalled cycles, then stream.
      cycle(1'b0, 1'b0, 2'd0, 4'b0001, 16'h0005, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'd0, 4'b1111, 16'h9876, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'd0, 4'b1111, 16'h1357, 1'b1);

      // Reset while a stalled word is pending; round-robin restarts at channel 0.
      cycle(1'b0, 1'b1, 2'd0, 4'b1111, 16'hCAFE, 1'b0);
      cycle(1'b1, 1'b1, 2'd0, 4'b1111, 16'hCAFE, 1'b0);
      cycle(1'b0, 1'b1, 2'd0, 4'b1111, 16'hBEEF, 1'b1);
      cycle(1'b0, 1'b1, 2'd0, 4'b1111, 16'hBEEF, 1'b1);

      // Fixed select of a channel that is not valid.
      cycle(1'b0, 1'b0, 2'd3, 4'b0111, 16'h0123, 1'b1);
      cycle(1'b0, 1'b0, 2'd3, 4'b0111, 16'h0123, 1'b1);
      cycle(1'b0, 1'b0, 2'd3, 4'b0111, 16'h0123, 1'b1);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 39) == 0);
         m = 1'($urandom_range(0, 1));
         s = 2'($urandom_range(0, 3));
         v = 4'($urandom);
         d = 16'($urandom);
         o = ($urandom_range(0, 9) < 7);
         cycle(r, m, s, v, d, o);
      end

      // Drain.
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'd0, 4'b0000, 16'h0, 1'b1);
      #3;
      done = 1'b1;
      chk("queue_drained", q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
